// File: rtl/execute_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | execute_stage : EX stage, single-cycle ALU plus iterative RV32M mul/div    |
// | Optional: RVGA_FAST_MUL_EN selects a combinational multiplier.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

package rvga_pkg;
  localparam int RVGA_XLEN = 32;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASSB, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  typedef struct packed {
    logic                 valid;
    alu_op_e              alu_op;
    logic [RVGA_XLEN-1:0] rs1_data;
    logic [RVGA_XLEN-1:0] rs2_data;
    logic [RVGA_XLEN-1:0] imm;
    logic                 alu_src_imm;
    logic                 regfile_load;
    logic [4:0]           rd;
    logic [RVGA_XLEN-1:0] rd_data;
  } rvga_cword;
endpackage

module execute_stage
  import rvga_pkg::*;
#(
  parameter int XLEN = RVGA_XLEN
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      stall,
  input  rvga_cword rf_ex_cword,
  output rvga_cword ex_mem_cword,
  output logic      ex_busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] c_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_e;

  state_e            r_state;
  logic [CW-1:0]     r_count;
  rvga_cword         r_word;
  logic [XLEN-1:0]   r_divisor;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg_res;
  logic              r_neg_rem;

  logic [XLEN-1:0]   w_op_a, w_op_b, w_mag_a, w_mag_b, w_alu_res, w_iter_res;
  logic [4:0]        w_shamt;
  logic              w_is_mul, w_is_div, w_iter, w_issue, w_a_signed, w_b_signed, w_sa, w_sb;
  logic [XLEN:0]     w_mul_sum, w_shift, w_diff;
  logic              w_qbit;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_step, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem;

  assign w_op_a  = rf_ex_cword.rs1_data;
  assign w_op_b  = rf_ex_cword.alu_src_imm ? rf_ex_cword.imm : rf_ex_cword.rs2_data;
  assign w_shamt = w_op_b[4:0];

  assign w_is_mul   = rf_ex_cword.alu_op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  assign w_is_div   = rf_ex_cword.alu_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign w_a_signed = rf_ex_cword.alu_op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  assign w_b_signed = rf_ex_cword.alu_op inside {ALU_MULH, ALU_DIV, ALU_REM};
  assign w_sa       = w_a_signed & w_op_a[XLEN-1];
  assign w_sb       = w_b_signed & w_op_b[XLEN-1];
  assign w_mag_a    = w_sa ? -w_op_a : w_op_a;
  assign w_mag_b    = w_sb ? -w_op_b : w_op_b;

`ifdef RVGA_FAST_MUL_EN
  logic [XLEN:0]     w_a_ext, w_b_ext;
  logic [2*XLEN+1:0] w_fast_prod;
  assign w_a_ext     = {w_sa, w_op_a};
  assign w_b_ext     = {w_sb, w_op_b};
  assign w_fast_prod = $signed({{(XLEN+1){w_a_ext[XLEN]}}, w_a_ext})
                     * $signed({{(XLEN+1){w_b_ext[XLEN]}}, w_b_ext});
  assign w_iter      = w_is_div;
`else
  assign w_iter      = w_is_mul | w_is_div;
`endif

  assign w_issue = (r_state == S_IDLE) && rf_ex_cword.valid && w_iter;
  assign ex_busy = rst_n && (w_issue || ((r_state != S_IDLE) && (r_count != c_LAST)));

  always_comb begin
    w_alu_res = '0;
    case (rf_ex_cword.alu_op)
      ALU_ADD:   w_alu_res = w_op_a + w_op_b;
      ALU_SUB:   w_alu_res = w_op_a - w_op_b;
      ALU_SLL:   w_alu_res = w_op_a << w_shamt;
      ALU_SLT:   w_alu_res = XLEN'($signed(w_op_a) < $signed(w_op_b));
      ALU_SLTU:  w_alu_res = XLEN'(w_op_a < w_op_b);
      ALU_XOR:   w_alu_res = w_op_a ^ w_op_b;
      ALU_SRL:   w_alu_res = w_op_a >> w_shamt;
      ALU_SRA:   w_alu_res = $unsigned($signed(w_op_a) >>> w_shamt);
      ALU_OR:    w_alu_res = w_op_a | w_op_b;
      ALU_AND:   w_alu_res = w_op_a & w_op_b;
      ALU_PASSB: w_alu_res = w_op_b;
`ifdef RVGA_FAST_MUL_EN
      ALU_MUL:   w_alu_res = w_fast_prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: w_alu_res = w_fast_prod[2*XLEN-1:XLEN];
`endif
      default:   w_alu_res = '0;
    endcase
  end

  // r_acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_divisor} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_shift    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_divisor};
  assign w_qbit     = ~w_diff[XLEN];
  assign w_div_next = {(w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0]), r_acc[XLEN-2:0], w_qbit};

`ifdef RVGA_FAST_MUL_EN
  assign w_step = w_div_next;
`else
  assign w_step = (r_state == S_MUL) ? w_mul_next : w_div_next;
`endif

  assign w_prod = r_neg_res ? -w_step : w_step;
  assign w_quo  = r_neg_res ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
  assign w_rem  = r_neg_rem ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];

  always_comb begin
    w_iter_res = '0;
    case (r_word.alu_op)
      ALU_MUL:                         w_iter_res = w_prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: w_iter_res = w_prod[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:               w_iter_res = w_quo;
      ALU_REM, ALU_REMU:               w_iter_res = w_rem;
      default:                         w_iter_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_cword <= '0;
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_word       <= '0;
      r_divisor    <= '0;
      r_acc        <= '0;
      r_neg_res    <= 1'b0;
      r_neg_rem    <= 1'b0;
    end else if (!stall) begin
      if (r_state == S_IDLE) begin
        if (w_issue) begin
          ex_mem_cword <= '0;
          r_word       <= rf_ex_cword;
          r_count      <= '0;
          r_divisor    <= w_mag_b;
          r_acc        <= {{XLEN{1'b0}}, w_mag_a};
          // A zero divisor keeps the all-ones quotient unsigned
          r_neg_res    <= (w_sa ^ w_sb) & ~(w_is_div & (w_op_b == '0));
          r_neg_rem    <= w_sa;
          r_state      <= w_is_div ? S_DIV : S_MUL;
        end else if (rf_ex_cword.valid) begin
          ex_mem_cword         <= rf_ex_cword;
          ex_mem_cword.rd_data <= w_alu_res;
        end else begin
          ex_mem_cword <= '0;
        end
      end else begin
        r_acc   <= w_step;
        r_count <= r_count + 1'b1;
        if (r_count == c_LAST) begin
          ex_mem_cword         <= r_word;
          ex_mem_cword.rd_data <= w_iter_res;
          r_state              <= S_IDLE;
          r_count              <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_execute_stage : directed + random checks of execute_stage vs a model    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_execute_stage;
  import rvga_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      stall = 1'b0;
  rvga_cword rf_ex_cword;
  rvga_cword ex_mem_cword;
  logic      ex_busy;
  int        tests = 0;
  int        fails = 0;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .rf_ex_cword(rf_ex_cword),
    .ex_mem_cword(ex_mem_cword), .ex_busy(ex_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input rvga_cword got, input rvga_cword exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(alu_op_e op, logic [31:0] a, logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [4:0]  sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sh = b[4:0];
    case (op)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_SLL:    return a << sh;
      ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
      ALU_XOR:    return a ^ b;
      ALU_SRL:    return a >> sh;
      ALU_SRA:    return 32'(sa >>> sh);
      ALU_OR:     return a | b;
      ALU_AND:    return a & b;
      ALU_PASSB:  return b;
      ALU_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
      ALU_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      ALU_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      ALU_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      ALU_DIV:    if (b == 0) return 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                  else return 32'(sa / sb);
      ALU_REM:    if (b == 0) return a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                  else return 32'(sa % sb);
      ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      ALU_REMU:   return (b == 0) ? a : 32'(ua % ub);
      default:    return 32'd0;
    endcase
  endfunction

  function automatic int exp_busy(alu_op_e op);
    if (op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) return 32;
`ifndef RVGA_FAST_MUL_EN
    if (op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU}) return 32;
`endif
    return 0;
  endfunction

  function automatic rvga_cword mk(alu_op_e op, logic [31:0] a, logic [31:0] b,
                                   logic use_imm, logic [31:0] imm);
    rvga_cword w;
    w.valid        = 1'b1;
    w.alu_op       = op;
    w.rs1_data     = a;
    w.rs2_data     = b;
    w.imm          = imm;
    w.alu_src_imm  = use_imm;
    w.regfile_load = 1'($urandom);
    w.rd           = 5'($urandom);
    w.rd_data      = $urandom;
    return w;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Presents w, follows the busy handshake, checks the result one edge after release
  task automatic run(input rvga_cword w, input string tag);
    rvga_cword exp;
    int        n;
    exp         = w;
    exp.rd_data = model(w.alu_op, w.rs1_data, w.alu_src_imm ? w.imm : w.rs2_data);
    rf_ex_cword = w;
    #1;
    n = 0;
    while (ex_busy && n < 40) begin
      n++;
      tick();
      if (n == 1) check_word({tag, "_bubble"}, ex_mem_cword, '0);
    end
    tick();
    check_word(tag, ex_mem_cword, exp);
    check_val({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy(w.alu_op)));
    rf_ex_cword = '0;
  endtask

  initial begin
    rvga_cword w, exp;
    int        cyc;
    alu_op_e   op;

    rf_ex_cword = '0;
    #1;
    check_word("reset_out", ex_mem_cword, '0);
    check_val("reset_busy", 32'(ex_busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    run(mk(ALU_ADD, 32'd5, 32'd7, 1'b0, 32'd0), "add_5_7");
    run(mk(ALU_SRA, 32'h8000_0000, $urandom, 1'b1, 32'h24), "sra_imm");
    run(mk(ALU_MULHU, 32'hFFFF_FFFF, 32'd3, 1'b0, 32'd0), "mulhu");
    run(mk(ALU_DIV, 32'd7, 32'd0, 1'b0, 32'd0), "div_by0");
    run(mk(ALU_REM, 32'd7, 32'd0, 1'b0, 32'd0), "rem_by0");
    run(mk(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0), "div_ovf");
    run(mk(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0), "rem_ovf");
    run(mk(ALU_DIV, -32'sd7, 32'd2, 1'b0, 32'd0), "div_neg");
    run(mk(ALU_REM, -32'sd7, 32'd2, 1'b0, 32'd0), "rem_neg");

    // back-to-back: SUB presented on the edge the DIVU completes
    run(mk(ALU_DIVU, 32'd1000, 32'd33, 1'b0, 32'd0), "b2b_divu");
    run(mk(ALU_SUB, 32'd9, 32'd4, 1'b0, 32'd0), "b2b_sub");
    tick();
    check_word("b2b_no_dup", ex_mem_cword, '0);

    // stall for three cycles while count is 10
    w           = mk(ALU_DIVU, 32'd100, 32'd7, 1'b0, 32'd0);
    exp         = w;
    exp.rd_data = 32'd14;
    rf_ex_cword = w;
    repeat (11) tick();
    stall = 1'b1;
    repeat (3) begin
      tick();
      check_word("stall_hold", ex_mem_cword, '0);
      check_val("stall_busy", 32'(ex_busy), 32'd1);
    end
    stall = 1'b0;
    cyc = 14;
    while (!ex_mem_cword.valid && cyc < 60) begin
      if (!ex_busy) rf_ex_cword = '0;
      tick();
      cyc++;
    end
    check_val("stall_latency", 32'(cyc), 32'd36);
    check_word("stall_result", ex_mem_cword, exp);
    rf_ex_cword = '0;

    // asynchronous reset in the middle of a divide
    rf_ex_cword = mk(ALU_DIV, 32'd12345, 32'd17, 1'b0, 32'd0);
    repeat (11) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_word("rst_mid_out", ex_mem_cword, '0);
    check_val("rst_mid_busy", 32'(ex_busy), 32'd0);
    rf_ex_cword = '0;
    tick();
    rst_n = 1'b1;
    run(mk(ALU_ADD, 32'd1, 32'd1, 1'b0, 32'd0), "rst_then_add");

    // randomized ops, including stall cycles between them
    for (int i = 0; i < 40; i++) begin
      op = alu_op_e'($urandom_range(0, 18));
      run(mk(op, pick(), pick(), 1'($urandom_range(0, 3) == 0), pick()),
          $sformatf("rand%0d_%s", i, op.name()));
      if ($urandom_range(0, 3) == 0) begin
        stall = 1'b1;
        rf_ex_cword = mk(ALU_XOR, $urandom, $urandom, 1'b0, 32'd0);
        w = ex_mem_cword;
        tick();
        check_word("rand_stall_hold", ex_mem_cword, w);
        stall = 1'b0;
        rf_ex_cword = '0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (EX) stage, directly downstream of the register-fetch stage.
- Consumes the control word carrying rs1_data/rs2_data and computes the result into rd_data.
- Registers the word to the memory stage.
- Base ALU ops are single-cycle; RV32M multiply/divide/remainder run iteratively. While they run, ex_busy holds the upstream stages.

Parameters:
- XLEN, 32, datapath width; counter width is clog2(XLEN).

Ports:
- clk  input  1  stage clock.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  global pipeline stall; freezes all state when 1.
- rf_ex_cword  input  rvga_cword  word from register fetch. Fields used: valid, alu_op, rs1_data, rs2_data, imm, alu_src_imm, regfile_load, rd.
- ex_mem_cword  output  rvga_cword  registered word to memory stage, with rd_data filled.
- ex_busy  output  1  combinational; holds register fetch and everything upstream while 1.

Behaviour:
- Reset (async, rst_n=0): ex_mem_cword=0, state=IDLE, count=0, ex_busy=0, operand/accumulator registers=0. Applies immediately, including mid-iteration; any in-flight op is discarded.
- Operand selection:
  - opA = rs1_data.
  - opB = alu_src_imm ? imm : rs2_data.
  - Shift amount = opB[4:0].
  - All arithmetic is modulo 2^XLEN.
- Single-cycle ops: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND, plus PASSB (for LUI).
  - Input in cycle N with stall=0 gives ex_mem_cword = input word with rd_data=result at edge N+1.
  - All other fields pass unchanged.
- Bubble: valid=0 with stall=0 gives ex_mem_cword <= 0.
- stall=1 freezes FSM, count, operand registers and ex_mem_cword. ex_busy keeps its value.
- FSM states: IDLE, MUL, DIV.
  - IDLE -> MUL on valid MUL/MULH/MULHSU/MULHU with stall=0.
  - IDLE -> DIV on valid DIV/DIVU/REM/REMU with stall=0.
  - Issue cycle: capture the word, take magnitudes of signed operands, record the result sign, count=0.
  - ex_busy=1 combinationally in the issue cycle.
  - ex_mem_cword <= 0 (bubble) at the issue edge.
- MUL state: unsigned shift-add, one multiplier bit per cycle.
- DIV state: restoring division, one quotient bit per cycle.
- Counting and completion:
  - count advances 0..XLEN-1 over cycles 1..XLEN.
  - ex_busy=1 while count != XLEN-1; ex_busy=0 in the final iteration cycle.
  - At the final edge: sign-correct the result, write ex_mem_cword with rd_data, return to IDLE. Upstream advances on the same edge.
  - The held input is never re-issued because state != IDLE during that cycle.
- Latency: issue at cycle 0, result visible at cycle XLEN+1; ex_busy high for cycles 0..XLEN-1.
- Multiply result selection:
  - MUL returns the low word.
  - MULH, MULHSU and MULHU return the high word of the signed/signed, signed/unsigned and unsigned/unsigned product respectively.
- Divide special cases follow RISC-V, with no early-out and the same latency:
  - Divide by 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - DIV of -2^(XLEN-1) by -1 gives -2^(XLEN-1); REM gives 0.
- Remainder sign equals the dividend sign.
- Back-to-back: a single-cycle op may issue in cycle XLEN+1 (first cycle after completion) and produces its result at cycle XLEN+2.

Optional Feature:
- Macro: RVGA_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU use a combinational 2*XLEN-bit product.
  - Latency 1, same as a single-cycle op; ex_busy never asserts for multiplies.
  - The MUL state is not synthesized.
- Undefined: iterative multiply as above. Division is iterative in both builds.

Test Plan:
- Reset during DIV: assert rst_n=0 at count 10 -> ex_mem_cword=0 and ex_busy=0 immediately, state IDLE. After release, ADD 1+1 -> rd_data=2 next cycle.
- ALU ops:
  - ADD rs1=5, rs2=7 -> rd_data=12 one cycle later, ex_busy stays 0.
  - SRA 0x80000000 by imm 0x24 (shamt 4) -> 0xF8000000.
- Iterative MULHU 0xFFFFFFFF*3 -> ex_busy high cycles 0..31; rd_data=0x00000002 at cycle 33. Under RVGA_FAST_MUL_EN: rd_data at cycle 1 with ex_busy never high.
- Divide corners:
  - DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
  - DIV -7/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
- Stall mid-op: DIVU 100/7 with stall=1 for 3 cycles at count 10 -> ex_mem_cword and count frozen; rd_data=14 at cycle 36.
- Back-to-back: DIVU then SUB 9-4 -> DIVU result at cycle 33, SUB rd_data=5 at cycle 34; no duplicate DIVU output.
